// File: rtl/hpdcache_pkg.sv
// Shared types for the multi-target MSHR: target record and entry state.
package hpdcache_pkg;
  localparam int unsigned HPDCACHE_MSHR_TID_W  = 6;
  localparam int unsigned HPDCACHE_MSHR_SID_W  = 3;
  localparam int unsigned HPDCACHE_MSHR_WORD_W = 3;

  typedef struct packed {
    logic [HPDCACHE_MSHR_TID_W-1:0]  tid;
    logic [HPDCACHE_MSHR_SID_W-1:0]  sid;
    logic [HPDCACHE_MSHR_WORD_W-1:0] word;
    logic                            need_rsp;
  } mshr_mt_target_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } mshr_mt_state_e;
endpackage

// File: rtl/hpdcache_mshr_mt_tlist.sv
// Per-entry target list: append at the tail, read by index, clear on entry release.
module hpdcache_mshr_mt_tlist
  import hpdcache_pkg::*;
#(
  parameter int unsigned NTARGETS = 4,
  parameter int unsigned CNT_W    = $clog2(NTARGETS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            push_i,
  input  mshr_mt_target_t push_data_i,
  input  logic [CNT_W-1:0] rd_idx_i,
  output mshr_mt_target_t rd_data_o,
  output logic [CNT_W-1:0] cnt_o
);
  mshr_mt_target_t  tgt_q [NTARGETS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;

  // A push in the same cycle as a clear lands in slot 0.
  assign cnt_base = clr_i ? '0 : cnt_q;
  assign cnt_o    = cnt_q;

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < int'(NTARGETS); i++) begin
      if (rd_idx_i == CNT_W'(i)) rd_data_o = tgt_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(NTARGETS); i++) tgt_q[i] <= '0;
    end else begin
      if (clr_i || push_i) cnt_q <= push_i ? cnt_base + CNT_W'(1) : '0;
      for (int i = 0; i < int'(NTARGETS); i++) begin
        if (push_i && (cnt_base == CNT_W'(i))) tgt_q[i] <= push_data_i;
      end
    end
  end
endmodule

// File: rtl/hpdcache_mshr_mt.sv
// Multi-target MSHR: line tags and entry states, primary/secondary allocation, and a
// drain engine that replays one entry's targets after its refill is acknowledged.
module hpdcache_mshr_mt
  import hpdcache_pkg::*;
#(
  parameter int unsigned NENTRIES = 4,
  parameter int unsigned NTARGETS = 4,
  parameter int unsigned SET_W    = 7,
  parameter int unsigned TAG_W    = 19,
  parameter int unsigned TID_W    = HPDCACHE_MSHR_TID_W,
  parameter int unsigned SID_W    = HPDCACHE_MSHR_SID_W,
  parameter int unsigned WORD_W   = HPDCACHE_MSHR_WORD_W,
  parameter int unsigned WAY_W    = 2,
  localparam int unsigned NLINE_W = TAG_W + SET_W,
  localparam int unsigned EIDX_W  = (NENTRIES > 1) ? $clog2(NENTRIES) : 1,
  localparam int unsigned CNT_W   = $clog2(NTARGETS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               empty_o,
  output logic               full_o,
  input  logic               alloc_valid_i,
  output logic               alloc_ready_o,
  input  logic [NLINE_W-1:0] alloc_nline_i,
  input  logic [TID_W-1:0]   alloc_tid_i,
  input  logic [SID_W-1:0]   alloc_sid_i,
  input  logic [WORD_W-1:0]  alloc_word_i,
  input  logic [WAY_W-1:0]   alloc_way_i,
  input  logic               alloc_need_rsp_i,
  output logic               alloc_primary_o,
  output logic [EIDX_W-1:0]  alloc_entry_o,
  input  logic               ack_i,
  input  logic [EIDX_W-1:0]  ack_entry_i,
  output logic               ack_ready_o,
  output logic [SET_W-1:0]   ack_set_o,
  output logic [TAG_W-1:0]   ack_tag_o,
  output logic [WAY_W-1:0]   ack_way_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [TID_W-1:0]   rsp_tid_o,
  output logic [SID_W-1:0]   rsp_sid_o,
  output logic [WORD_W-1:0]  rsp_word_o,
  output logic               rsp_need_rsp_o,
  output logic               rsp_last_o
);
  localparam logic [0:0] DRAIN_IDLE = 1'b0;
  localparam logic [0:0] DRAIN_BUSY = 1'b1;

  mshr_mt_state_e     state_q [NENTRIES];
  mshr_mt_state_e     state_d [NENTRIES];
  logic [NLINE_W-1:0] nline_q [NENTRIES];
  logic [WAY_W-1:0]   way_q   [NENTRIES];
  logic [0:0]         drain_q, drain_d;
  logic [EIDX_W-1:0]  drain_entry_q, drain_entry_d;
  logic [CNT_W-1:0]   drain_idx_q, drain_idx_d;

  logic [NENTRIES-1:0] match_pend, match_drain, is_free, push, clr;
  logic [CNT_W-1:0]    cnt     [NENTRIES];
  mshr_mt_target_t     rd_data [NENTRIES];
  logic [EIDX_W-1:0]   pend_idx, free_idx;
  logic [NLINE_W-1:0]  sel_nline;
  logic [CNT_W-1:0]    sel_cnt;
  mshr_mt_target_t     alloc_tgt, rsp_tgt;
  logic                busy, ack_fire, rsp_fire, rsp_last;

  // Reverse scan so the lowest matching / free index wins.
  always_comb begin
    match_pend  = '0;
    match_drain = '0;
    is_free     = '0;
    pend_idx    = '0;
    free_idx    = '0;
    for (int i = int'(NENTRIES) - 1; i >= 0; i--) begin
      match_pend[i]  = (state_q[i] == PENDING) && (nline_q[i] == alloc_nline_i);
      match_drain[i] = (state_q[i] == DRAIN) && (nline_q[i] == alloc_nline_i);
      is_free[i]     = (state_q[i] == FREE);
      if (match_pend[i]) pend_idx = EIDX_W'(i);
      if (is_free[i])    free_idx = EIDX_W'(i);
    end
  end

  assign busy        = (drain_q == DRAIN_BUSY);
  assign ack_ready_o = !busy;
  assign ack_fire    = ack_i && ack_ready_o && (state_q[ack_entry_i] == PENDING);
  assign empty_o     = &is_free;
  assign full_o      = ~|is_free;

  // A merge into the entry being acked this cycle is refused: it leaves PENDING at the edge.
  always_comb begin
    alloc_ready_o   = 1'b0;
    alloc_primary_o = 1'b0;
    alloc_entry_o   = '0;
    if (alloc_valid_i) begin
      if (|match_pend) begin
        alloc_entry_o = pend_idx;
        alloc_ready_o = (cnt[pend_idx] < CNT_W'(NTARGETS)) &&
                        !(ack_fire && (ack_entry_i == pend_idx));
      end else if (!(|match_drain) && (|is_free)) begin
        alloc_entry_o   = free_idx;
        alloc_ready_o   = 1'b1;
        alloc_primary_o = 1'b1;
      end
    end
  end

  assign alloc_tgt = '{tid: alloc_tid_i, sid: alloc_sid_i, word: alloc_word_i,
                       need_rsp: alloc_need_rsp_i};

  for (genvar g = 0; g < int'(NENTRIES); g++) begin : gen_tlist
    assign push[g] = alloc_ready_o && (alloc_entry_o == EIDX_W'(g));
    hpdcache_mshr_mt_tlist #(
      .NTARGETS (NTARGETS),
      .CNT_W    (CNT_W)
    ) i_tlist (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_i       (clr[g]),
      .push_i      (push[g]),
      .push_data_i (alloc_tgt),
      .rd_idx_i    (drain_idx_q),
      .rd_data_o   (rd_data[g]),
      .cnt_o       (cnt[g])
    );
  end

  assign sel_nline = nline_q[drain_entry_q];
  assign sel_cnt   = cnt[drain_entry_q];
  assign rsp_tgt   = rd_data[drain_entry_q];
  assign rsp_last  = busy && ((drain_idx_q + CNT_W'(1)) == sel_cnt);
  assign rsp_fire  = busy && rsp_ready_i;

  assign rsp_valid_o    = busy;
  assign rsp_last_o     = rsp_last;
  assign rsp_tid_o      = busy ? rsp_tgt.tid : '0;
  assign rsp_sid_o      = busy ? rsp_tgt.sid : '0;
  assign rsp_word_o     = busy ? rsp_tgt.word : '0;
  assign rsp_need_rsp_o = busy ? rsp_tgt.need_rsp : 1'b0;
  assign ack_set_o      = busy ? sel_nline[SET_W-1:0] : '0;
  assign ack_tag_o      = busy ? sel_nline[NLINE_W-1:SET_W] : '0;
  assign ack_way_o      = busy ? way_q[drain_entry_q] : '0;

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    drain_entry_d = drain_entry_q;
    drain_idx_d   = drain_idx_q;
    clr           = '0;
    if (alloc_primary_o) state_d[alloc_entry_o] = PENDING;
    if (ack_fire) begin
      state_d[ack_entry_i] = DRAIN;
      drain_d              = DRAIN_BUSY;
      drain_entry_d        = ack_entry_i;
      drain_idx_d          = '0;
    end
    if (rsp_fire) begin
      if (rsp_last) begin
        state_d[drain_entry_q] = FREE;
        clr[drain_entry_q]     = 1'b1;
        drain_d                = DRAIN_IDLE;
        drain_entry_d          = '0;
        drain_idx_d            = '0;
      end else begin
        drain_idx_d = drain_idx_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NENTRIES); i++) begin
        state_q[i] <= FREE;
        nline_q[i] <= '0;
        way_q[i]   <= '0;
      end
      drain_q       <= DRAIN_IDLE;
      drain_entry_q <= '0;
      drain_idx_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NENTRIES); i++) state_q[i] <= state_d[i];
      if (alloc_primary_o) begin
        nline_q[alloc_entry_o] <= alloc_nline_i;
        way_q[alloc_entry_o]   <= alloc_way_i;
      end
      drain_q       <= drain_d;
      drain_entry_q <= drain_entry_d;
      drain_idx_q   <= drain_idx_d;
    end
  end

  a_nline_unique: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(match_pend | match_drain));
  a_ack_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ack_i && ack_ready_o) |-> (state_q[ack_entry_i] == PENDING));
  a_rsp_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_o |-> (busy && (state_q[drain_entry_q] == DRAIN)));
endmodule
